// File: rtl/alu_rr_sched.sv
// Round-robin front end sharing one W-bit ALU (with iterative restoring divider)
// between two requesters. Define ALU_RR_FLAGS_EN to add the rsp_flags output.
module alu_rr_sched #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [2:0]   req0_op,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [2:0]   req1_op,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_data,
`ifdef ALU_RR_FLAGS_EN
  output logic [3:0]   rsp_flags,
`endif
  output logic         busy
);

  localparam int CW = $clog2(W);
  localparam logic [2:0] OP_DIV = 3'b011;

  typedef enum logic [1:0] {IDLE, DIV, RESP} state_t;

  state_t        state, state_nxt;
  logic          last_grant;
  logic          grant0, grant1, accept, start_div, div_done;
  logic          sel_id;
  logic [2:0]    sel_op;
  logic [W-1:0]  sel_a, sel_b, alu_res;
  logic [W-1:0]  quot, divisor, rem, quot_nxt, rem_nxt;
  logic [W:0]    trial, diff;
  logic [CW-1:0] cnt;

  // On a tie the requester that was not served last wins.
  always_comb begin
    grant1     = req1_valid && (!req0_valid || !last_grant);
    grant0     = req0_valid && !grant1;
    req0_ready = (state == IDLE) && rst_n && grant0;
    req1_ready = (state == IDLE) && rst_n && grant1;
    accept     = req0_ready || req1_ready;
    sel_id     = grant1;
    sel_op     = grant1 ? req1_op : req0_op;
    sel_a      = grant1 ? req1_a  : req0_a;
    sel_b      = grant1 ? req1_b  : req0_b;
    start_div  = accept && (sel_op == OP_DIV) && (sel_b != '0);
  end

  // Single-cycle ops; a divide only lands here when the divisor is zero.
  always_comb begin
    alu_res = '0;
    case (sel_op)
      3'b000:  alu_res = sel_a + sel_b;
      3'b001:  alu_res = sel_a - sel_b;
      3'b010:  alu_res = sel_a * sel_b;
      3'b100:  alu_res = ~sel_a;
      3'b101:  alu_res = sel_a & sel_b;
      3'b110:  alu_res = sel_a | sel_b;
      3'b111:  alu_res = sel_a ^ sel_b;
      default: alu_res = '0;
    endcase
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    trial    = {rem, quot[W-1]};
    diff     = trial - {1'b0, divisor};
    rem_nxt  = diff[W] ? trial[W-1:0] : diff[W-1:0];
    quot_nxt = {quot[W-2:0], !diff[W]};
    div_done = (state == DIV) && (cnt == CW'(W - 1));
  end

`ifdef ALU_RR_FLAGS_EN
  logic [3:0] alu_flags, div_flags;

  always_comb begin
    alu_flags = {alu_res[W-1], alu_res == '0, 1'b0, 1'b0};
    case (sel_op)
      3'b000: begin
        alu_flags[1] = alu_res < sel_a;
        alu_flags[0] = (sel_a[W-1] == sel_b[W-1]) && (alu_res[W-1] != sel_a[W-1]);
      end
      3'b001: begin
        alu_flags[1] = sel_a < sel_b;
        alu_flags[0] = (sel_a[W-1] != sel_b[W-1]) && (alu_res[W-1] != sel_a[W-1]);
      end
      OP_DIV:  alu_flags[0] = 1'b1;
      default: ;
    endcase
    div_flags = {quot_nxt[W-1], quot_nxt == '0, 2'b00};
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (accept) state_nxt = start_div ? DIV : RESP;
      end
      DIV:  if (div_done) state_nxt = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
      quot       <= '0;
      divisor    <= '0;
      rem        <= '0;
      cnt        <= '0;
`ifdef ALU_RR_FLAGS_EN
      rsp_flags  <= '0;
`endif
    end else begin
      if (accept) begin
        last_grant <= sel_id;
        rsp_id     <= sel_id;
        if (start_div) begin
          quot    <= sel_a;
          divisor <= sel_b;
          rem     <= '0;
          cnt     <= '0;
        end else begin
          rsp_data <= alu_res;
`ifdef ALU_RR_FLAGS_EN
          rsp_flags <= alu_flags;
`endif
        end
      end
      if (state == DIV) begin
        quot <= quot_nxt;
        rem  <= rem_nxt;
        cnt  <= cnt + CW'(1);
        if (div_done) begin
          rsp_data <= quot_nxt;
`ifdef ALU_RR_FLAGS_EN
          rsp_flags <= div_flags;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_rr_sched.sv
// Bench for alu_rr_sched (W=8): a transaction-level model predicts readys, busy and
// responses every cycle under directed and random traffic.
module tb_alu_rr_sched;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req1_valid, rsp_ready;
  logic         req0_ready, req1_ready, rsp_valid, rsp_id, busy;
  logic [2:0]   req0_op, req1_op;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b, rsp_data;
`ifdef ALU_RR_FLAGS_EN
  logic [3:0]   rsp_flags;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int n_rsp    = 0;
  int grant_log[$];

  int           m_wait;
  bit           m_pend, m_last, m_id;
  logic [W-1:0] m_data;
`ifdef ALU_RR_FLAGS_EN
  logic [3:0]   m_flags;
`endif

  alu_rr_sched #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data),
`ifdef ALU_RR_FLAGS_EN
    .rsp_flags(rsp_flags),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [W-1:0] refData(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int ia, ib, r;
    ia = a; ib = b;
    case (op)
      3'd0: r = ia + ib;
      3'd1: r = ia - ib;
      3'd2: r = ia * ib;
      3'd3: r = (ib == 0) ? 0 : ia / ib;
      3'd4: r = ~ia;
      3'd5: r = ia & ib;
      3'd6: r = ia | ib;
      default: r = ia ^ ib;
    endcase
    return r[W-1:0];
  endfunction

`ifdef ALU_RR_FLAGS_EN
  function automatic logic [3:0] refFlags(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] d;
    int sa, sb, s;
    logic c, v;
    d = refData(op, a, b);
    sa = $signed(a); sb = $signed(b);
    c = 1'b0; v = 1'b0;
    if (op == 3'd0) begin
      c = (int'(a) + int'(b)) > 255;
      s = sa + sb;
      v = (s > 127) || (s < -128);
    end
    if (op == 3'd1) begin
      c = a < b;
      s = sa - sb;
      v = (s > 127) || (s < -128);
    end
    if (op == 3'd3 && b == 0) v = 1'b1;
    return {d[W-1], d == 0, c, v};
  endfunction
`endif

  // Reference model: one command in flight, response after 1 or W+1 cycles, then a bubble.
  always @(negedge clk) begin
    bit g0, g1, idle;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    if (!rst_n) begin
      checkOutput("reset_rsp_valid", rsp_valid, 0);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_req0_ready", req0_ready, 0);
      checkOutput("reset_req1_ready", req1_ready, 0);
      checkOutput("reset_rsp_id", rsp_id, 0);
      checkOutput("reset_rsp_data", rsp_data, 0);
`ifdef ALU_RR_FLAGS_EN
      checkOutput("reset_rsp_flags", rsp_flags, 0);
`endif
      m_wait = 0; m_pend = 0; m_last = 1;
    end else begin
      idle = !m_pend && (m_wait == 0);
      g0 = 0; g1 = 0;
      if (idle && req0_valid && req1_valid) begin
        g0 = m_last; g1 = !m_last;
      end else if (idle) begin
        g0 = req0_valid; g1 = req1_valid;
      end
      checkOutput("req0_ready", req0_ready, g0);
      checkOutput("req1_ready", req1_ready, g1);
      checkOutput("busy", busy, !idle);
      checkOutput("rsp_valid", rsp_valid, m_pend);
      if (m_pend) begin
        checkOutput("rsp_id", rsp_id, m_id);
        checkOutput("rsp_data", rsp_data, m_data);
`ifdef ALU_RR_FLAGS_EN
        checkOutput("rsp_flags", rsp_flags, m_flags);
`endif
      end
      if (req0_valid && req0_ready) grant_log.push_back(0);
      if (req1_valid && req1_ready) grant_log.push_back(1);
      if (m_pend) begin
        if (rsp_ready) begin
          m_pend = 0;
          n_rsp++;
        end
      end else if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) m_pend = 1;
      end else if (g0 || g1) begin
        op = g1 ? req1_op : req0_op;
        a  = g1 ? req1_a  : req0_a;
        b  = g1 ? req1_b  : req0_b;
        m_id = g1; m_last = g1;
        m_data = refData(op, a, b);
`ifdef ALU_RR_FLAGS_EN
        m_flags = refFlags(op, a, b);
`endif
        if (op == 3'd3 && b != 0) m_wait = W;
        else m_pend = 1;
      end
    end
  end

  // Issue one command and return at posedge+1 of the first rsp_valid cycle; lat counts
  // cycles from the accept cycle. With poke, the other requester is held valid meanwhile.
  task automatic applyStimulus(input bit id, input logic [2:0] op, input logic [W-1:0] a,
                               input logic [W-1:0] b, input bit poke, output int lat);
    bit acc;
    acc = 0; lat = 0;
    if (id) begin req1_valid = 1; req1_op = op; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1; req0_op = op; req0_a = a; req0_b = b; end
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      acc = id ? (req1_valid && req1_ready) : (req0_valid && req0_ready);
      @(posedge clk); #1;
    end
    if (id) req1_valid = 0; else req0_valid = 0;
    if (!acc) begin
      checkOutput("accept_timeout", 0, 1);
      return;
    end
    lat = 1;
    if (poke) begin if (id) req0_valid = 1; else req1_valid = 1; end
    while (!rsp_valid && lat < 50) begin
      #1;
      if (poke) checkOutput("div_other_ready", id ? req0_ready : req1_ready, 0);
      @(posedge clk); #1;
      lat++;
    end
    if (poke) begin if (id) req0_valid = 0; else req1_valid = 0; end
  endtask

  initial begin
    int lat;
    bit a0, a1, tmo;
    rst_n = 0; rsp_ready = 1;
    req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
    req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_busy", busy, 0);

    // Add with wrap: FE + 02 = 00, carry and zero set.
    req0_valid = 1; req0_op = 3'd0; req0_a = 8'hFE; req0_b = 8'h02;
    rst_n = 1;
    #1 checkOutput("release_req0_ready", req0_ready, 1);
    applyStimulus(0, 3'd0, 8'hFE, 8'h02, 0, lat);
    checkOutput("add_latency", lat, 1);
    checkOutput("add_id", rsp_id, 0);
    checkOutput("add_data", rsp_data, 8'h00);
`ifdef ALU_RR_FLAGS_EN
    checkOutput("add_flags", rsp_flags, 4'b0110);
`endif
    @(posedge clk); #1;

    // Divide from requester 1 while requester 0 waits.
    applyStimulus(1, 3'd3, 8'd200, 8'd7, 1, lat);
    checkOutput("div_latency", lat, 9);
    checkOutput("div_id", rsp_id, 1);
    checkOutput("div_data", rsp_data, 8'd28);
    @(posedge clk); #1;

    applyStimulus(0, 3'd3, 8'h55, 8'h00, 0, lat);
    checkOutput("div0_latency", lat, 1);
    checkOutput("div0_data", rsp_data, 8'h00);
`ifdef ALU_RR_FLAGS_EN
    checkOutput("div0_overflow", rsp_flags[0], 1);
`endif
    @(posedge clk); #1;

    // Both requesters always valid: grants alternate starting with 0 after reset.
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    grant_log.delete();
    req0_op = 3'd0; req0_a = 8'd1; req0_b = 8'd2; req0_valid = 1;
    req1_op = 3'd0; req1_a = 8'd3; req1_b = 8'd4; req1_valid = 1;
    tmo = 1;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (grant_log.size() >= 8) begin tmo = 0; break; end
    end
    req0_valid = 0; req1_valid = 0;
    checkOutput("alternate_timeout", tmo, 0);
    for (int i = 0; i < 8 && i < grant_log.size(); i++)
      checkOutput("alternate_grant", grant_log[i], i % 2);
    repeat (3) @(posedge clk);
    #1;

    // Stalled response stays stable and blocks new grants; then reset aborts a divide.
    rsp_ready = 0;
    applyStimulus(0, 3'd2, 8'h12, 8'h10, 0, lat);
    req1_op = 3'd3; req1_a = 8'd99; req1_b = 8'd5; req1_valid = 1;
    for (int k = 0; k < 5; k++) begin
      #1;
      checkOutput("hold_valid", rsp_valid, 1);
      checkOutput("hold_data", rsp_data, 8'h20);
      checkOutput("hold_id", rsp_id, 0);
      checkOutput("hold_req1_ready", req1_ready, 0);
      @(posedge clk); #1;
    end
    rsp_ready = 1;
    @(posedge clk); #1;
    checkOutput("after_hold_req1_ready", req1_ready, 1);
    @(posedge clk); #1;
    req1_valid = 0;
    @(posedge clk); #1;
    checkOutput("mid_div_busy", busy, 1);
    rst_n = 0;
    #1;
    checkOutput("abort_div_valid", rsp_valid, 0);
    checkOutput("abort_div_busy", busy, 0);
    checkOutput("abort_div_data", rsp_data, 0);
    @(posedge clk); #1;
    rst_n = 1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      checkOutput("abort_div_no_rsp", rsp_valid, 0);
    end

    // Reset while a response is pending discards it.
    rsp_ready = 0;
    applyStimulus(1, 3'd7, 8'h3C, 8'h0F, 0, lat);
    checkOutput("xor_data", rsp_data, 8'h33);
    rst_n = 0;
    #1;
    checkOutput("abort_rsp_valid", rsp_valid, 0);
    checkOutput("abort_rsp_data", rsp_data, 0);
    @(posedge clk); #1;
    rst_n = 1; rsp_ready = 1;
    repeat (3) begin
      @(posedge clk); #1;
      checkOutput("abort_rsp_no_rsp", rsp_valid, 0);
    end

    // Random traffic: each requester holds its command until accepted.
    n_rsp = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      @(posedge clk); #1;
      if (a0 || !req0_valid) begin
        req0_valid = ($urandom_range(0, 3) != 0);
        req0_op    = 3'($urandom_range(0, 7));
        req0_a     = 8'($urandom);
        req0_b     = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      end
      if (a1 || !req1_valid) begin
        req1_valid = ($urandom_range(0, 3) != 0);
        req1_op    = 3'($urandom_range(0, 7));
        req1_a     = 8'($urandom);
        req1_b     = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    repeat (15) @(posedge clk);
    #1;
    checkOutput("random_rsp_count_ok", n_rsp > 100, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
